// File: rtl/vec_math_pkg.sv
// Shared constants, op encoding and saturation limits for the vector add/sub datapath.
// Pure declarations: no latency or flow control of its own.
package vec_math_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ARRAY_SIZE = 3;
  localparam int DEFAULT_OUT_DEPTH  = 4;

  typedef enum logic {
    OP_SUB = 1'b0,
    OP_ADD = 1'b1
  } op_e;

  // Limits are returned in the low `width` bits of a 64-bit word; callers slice them.
  function automatic logic [63:0] sat_max(input int unsigned width);
    sat_max = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    sat_min = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/vec_fifo_buf.sv
// First-word-fall-through buffer, 1-cycle write-to-visible latency; head reads 0 while empty.
// Push is refused only when full without a same-cycle pop; pop while empty is ignored.
module vec_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer increment wraps for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset) !(push && full && !pop));

endmodule

// File: rtl/vec_addsub.sv
// Lane-wise signed add/sub with overflow flags into a FWFT result buffer, 1-cycle latency.
// Pops upstream only when the buffer has room or drains this cycle; VEC_ADDSUB_SAT_EN selects clamp vs wrap.
module vec_addsub
  import vec_math_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int OUT_DEPTH  = DEFAULT_OUT_DEPTH
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] x,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] y,
  input  logic                                  op,
  input  logic                                  in_empty,
  output logic                                  in_rd_en,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out,
  output logic [ARRAY_SIZE-1:0]                 out_ovf,
  output logic                                  out_empty,
  input  logic                                  out_rd_en,
  output logic [$clog2(OUT_DEPTH):0]            out_count
);

  localparam int LANE_W = DATA_WIDTH + 1;
  localparam int BUF_W  = ARRAY_SIZE * LANE_W;

`ifdef VEC_ADDSUB_SAT_EN
  localparam logic [63:0]           SAT_MAX64 = sat_max(DATA_WIDTH);
  localparam logic [63:0]           SAT_MIN64 = sat_min(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX   = SAT_MAX64[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] SAT_MIN   = SAT_MIN64[DATA_WIDTH-1:0];
`endif

  logic [ARRAY_SIZE-1:0][DATA_WIDTH:0]   ext_res;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] lane_res;
  logic [ARRAY_SIZE-1:0]                 lane_ovf;
  logic [ARRAY_SIZE-1:0][LANE_W-1:0]     wr_dat;
  logic [ARRAY_SIZE-1:0][LANE_W-1:0]     rd_dat;
  logic                                  buf_full;

  // The DATA_WIDTH+1 result is exact; overflow shows as its top two bits disagreeing.
  always_comb begin
    ext_res  = '0;
    lane_res = '0;
    lane_ovf = '0;
    wr_dat   = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (op_e'(op) == OP_ADD) begin
        ext_res[i] = {x[i][DATA_WIDTH-1], x[i]} + {y[i][DATA_WIDTH-1], y[i]};
      end else begin
        ext_res[i] = {x[i][DATA_WIDTH-1], x[i]} - {y[i][DATA_WIDTH-1], y[i]};
      end
      lane_ovf[i] = ext_res[i][DATA_WIDTH] ^ ext_res[i][DATA_WIDTH-1];
`ifdef VEC_ADDSUB_SAT_EN
      if (lane_ovf[i]) begin
        lane_res[i] = ext_res[i][DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      end else begin
        lane_res[i] = ext_res[i][DATA_WIDTH-1:0];
      end
`else
      lane_res[i] = ext_res[i][DATA_WIDTH-1:0];
`endif
      wr_dat[i] = {lane_ovf[i], lane_res[i]};
    end
  end

  // A full buffer can still accept when the head leaves in the same cycle.
  assign in_rd_en = reset && !in_empty && (!buf_full || out_rd_en);

  vec_fifo_buf #(
    .WIDTH (BUF_W),
    .DEPTH (OUT_DEPTH)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (in_rd_en),
    .push_dat (wr_dat),
    .pop      (out_rd_en),
    .pop_dat  (rd_dat),
    .empty    (out_empty),
    .full     (buf_full),
    .count    (out_count)
  );

  always_comb begin
    out     = '0;
    out_ovf = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      out[i]     = rd_dat[i][DATA_WIDTH-1:0];
      out_ovf[i] = rd_dat[i][DATA_WIDTH];
    end
  end

endmodule

// File: doc/vec_addsub.md
VEC_ADDSUB -- requirements
Module: vec_addsub

Interface
- REQ-001 Parameter DATA_WIDTH, default 32: signed two's-complement width of each lane.
- REQ-002 Parameter ARRAY_SIZE, default 3: number of lanes per vector.
- REQ-003 Parameter OUT_DEPTH, default 4: output buffer entries; power of two, at least 2.
- REQ-004 clock  input  1  single clock; all state updates on its rising edge.
- REQ-005 reset  input  1  synchronous, active-low reset; sampled only at the rising edge of clock.
- REQ-006 x  input  DATA_WIDTH x ARRAY_SIZE  first operand vector, head of the upstream FIFO.
- REQ-007 y  input  DATA_WIDTH x ARRAY_SIZE  second operand vector, head of the upstream FIFO.
- REQ-008 op  input  1  0 = subtract (x-y), 1 = add (x+y); travels with x/y.
- REQ-009 in_empty  input  1  upstream has no valid x/y/op.
- REQ-010 in_rd_en  output  1  pops x/y/op from upstream this cycle.
- REQ-011 out  output  DATA_WIDTH x ARRAY_SIZE  result vector at the buffer head.
- REQ-012 out_ovf  output  ARRAY_SIZE  per-lane signed-overflow flag for the head result.
- REQ-013 out_empty  output  1  output buffer holds no result.
- REQ-014 out_rd_en  input  1  downstream pops the head result.
- REQ-015 out_count  output  clog2(OUT_DEPTH)+1  number of buffered results.

Function
- REQ-016 Per lane i: r[i] = op ? x[i]+y[i] : x[i]-y[i], computed at DATA_WIDTH+1 bits.
- REQ-017 ovf[i] = 1 when the exact result falls outside the signed DATA_WIDTH range.
- REQ-018 in_rd_en = !in_empty && (out_count < OUT_DEPTH || out_rd_en); it is combinational.
- REQ-019 When in_rd_en=1, {r, ovf} is written to the buffer at that edge, giving 1-cycle latency: out_empty falls after the same edge.
- REQ-020 The output is first-word-fall-through: out/out_ovf show the head entry whenever out_empty=0.
- REQ-021 out_rd_en with out_empty=1 is ignored; no pointer or count change.
- REQ-022 A simultaneous push and pop leaves out_count unchanged; this is legal when the buffer is full and when out_count=1.
- REQ-023 Read and write pointers wrap modulo OUT_DEPTH with no bubble.
- REQ-024 out and out_ovf are driven to 0 while out_empty=1.
- REQ-025 Results leave the buffer in strict input order; none is dropped or duplicated.

Reset
- REQ-026 With reset=0 at a rising edge: pointers=0, out_count=0, out_empty=1, out=0, out_ovf=0.
- REQ-027 A reset mid-operation discards all buffered results.
- REQ-028 While reset=0, in_rd_en is forced to 0.
- REQ-029 Normal operation resumes on the first edge with reset=1.

Configuration
- REQ-030 Macro VEC_ADDSUB_SAT_EN defined: overflowing lanes clamp to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
- REQ-031 Macro VEC_ADDSUB_SAT_EN undefined: overflowing lanes wrap modulo 2^DATA_WIDTH.
- REQ-032 out_ovf is reported identically in both builds.

Structure
- REQ-033 Package vec_math_pkg holds: default DATA_WIDTH/ARRAY_SIZE constants, the op encoding enum (OP_SUB=0, OP_ADD=1), and sat-min/max constant functions.
- REQ-034 The storage is one sub-module, vec_fifo_buf, a FWFT buffer parametrised by width and OUT_DEPTH; vec_addsub instantiates it once with width ARRAY_SIZE*(DATA_WIDTH+1).

Verification
- REQ-035 Subtract: x={5,0,-3}, y={2,7,-3}, op=0 -> out={3,-7,0}, ovf=000, one cycle after the pop.
- REQ-036 Add: x={0x7FFFFFFF,1,-1}, y={1,1,1}, op=1 -> ovf lane0=1; SAT build lane0=0x7FFFFFFF, wrap build lane0=0x80000000; lanes1/2 = 2, 0.
- REQ-037 Back-pressure: hold out_rd_en=0 and feed 6 vectors -> exactly OUT_DEPTH accepted, in_rd_en=0 afterwards; then assert out_rd_en continuously -> all 6 emerge in order.
- REQ-038 Full buffer plus simultaneous out_rd_en and valid input -> in_rd_en=1, out_count stays 4, order preserved across pointer wrap.
- REQ-039 Reset asserted with 3 entries buffered -> next cycle out_empty=1, out_count=0, out=0, and no stale data after reset is released.
- REQ-040 Random stream of 1000 vectors with random op and random stalls on both sides -> out matches the reference model bit-exactly, with zero errors.
